// File: rtl/two_ch_frame_merger.sv
// Two-channel frame merger: per-channel word FIFOs with whole-frame admission and round-robin
// frame forwarding. Define FRAME_CHECK_EN to enable header/footer ID checks (CHECK_ERR).
module two_ch_frame_merger #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ch0_valid_i,
  input  logic [DATA_WIDTH-1:0] ch0_data_i,
  input  logic                  ch1_valid_i,
  input  logic [DATA_WIDTH-1:0] ch1_data_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  m_ch_o,
  output logic [15:0]           drop_cnt0_o,
  output logic [15:0]           drop_cnt1_o,
  output logic [1:0]            check_err_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_WIDTH:0] RemOne = (LEN_WIDTH+1)'(1);

  typedef enum logic [1:0] {WIdle, WAccept, WDiscard} w_state_e;
  typedef enum logic {RIdle, RStream} r_state_e;

  logic [1:0]            in_valid;
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [LEN_WIDTH-1:0]  hdr_len [2];

  assign in_valid   = {ch1_valid_i, ch0_valid_i};
  assign in_data[0] = ch0_data_i;
  assign in_data[1] = ch1_data_i;
  assign hdr_len[0] = ch0_data_i[LEN_WIDTH-1:0];
  assign hdr_len[1] = ch1_data_i[LEN_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem_q [2][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q [2];
  logic [AW-1:0]         rd_ptr_q [2];
  logic [AW:0]           occ_q [2];
  logic [AW:0]           frames_q [2];
  logic [15:0]           drop_q [2];
  w_state_e              w_state_q [2];
  w_state_e              w_state_d [2];
  logic [LEN_WIDTH:0]    w_rem_q [2];
  logic [LEN_WIDTH:0]    w_rem_d [2];
  logic [1:0]            push, pop, frame_done, drop, frame_dec;

`ifdef FRAME_CHECK_EN
  logic [1:0] err_q, err_d;
`endif

  // Writers: admission uses occupancy as of the header cycle; same-cycle pops are not credited.
  always_comb begin
`ifdef FRAME_CHECK_EN
    err_d = err_q;
`endif
    for (int c = 0; c < 2; c++) begin
      w_state_d[c]  = w_state_q[c];
      w_rem_d[c]    = w_rem_q[c];
      push[c]       = 1'b0;
      frame_done[c] = 1'b0;
      drop[c]       = 1'b0;
      if (in_valid[c]) begin
        unique case (w_state_q[c])
          WIdle: begin
`ifdef FRAME_CHECK_EN
            if (in_data[c][DATA_WIDTH-1 -: 16] != 16'hAAAA) err_d[c] = 1'b1;
            else
`endif
            if (hdr_len[c] == '0 ||
                (FIFO_DEPTH - 32'(occ_q[c])) < (32'(hdr_len[c]) + 32'd2)) begin
              drop[c]      = 1'b1;
              w_state_d[c] = WDiscard;
              w_rem_d[c]   = {1'b0, hdr_len[c]} + 1'b1;
            end else begin
              push[c]      = 1'b1;
              w_state_d[c] = WAccept;
              w_rem_d[c]   = {1'b0, hdr_len[c]} + 1'b1;
            end
          end
          WAccept: begin
            push[c]    = 1'b1;
            w_rem_d[c] = w_rem_q[c] - 1'b1;
            if (w_rem_q[c] == RemOne) begin
              w_state_d[c]  = WIdle;
              frame_done[c] = 1'b1;
`ifdef FRAME_CHECK_EN
              if (in_data[c][15:0] != 16'h5555) err_d[c] = 1'b1;
`endif
            end
          end
          WDiscard: begin
            w_rem_d[c] = w_rem_q[c] - 1'b1;
            if (w_rem_q[c] == RemOne) w_state_d[c] = WIdle;
          end
          default: w_state_d[c] = WIdle;
        endcase
      end
    end
  end

  r_state_e              r_state_q;
  logic                  r_ch_q, last_served_q;
  logic [LEN_WIDTH:0]    r_rem_q;
  logic                  m_valid_q, m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [1:0]            has_frame;
  logic                  r_start, r_pick, r_sel, r_accept, r_advance, r_done;
  logic [DATA_WIDTH-1:0] rd_word;

  assign has_frame = {frames_q[1] != '0, frames_q[0] != '0};

  always_comb begin
    r_start   = (r_state_q == RIdle) && (has_frame != 2'b00);
    r_pick    = (has_frame == 2'b11) ? ~last_served_q : has_frame[1];
    r_sel     = r_start ? r_pick : r_ch_q;
    rd_word   = mem_q[r_sel][rd_ptr_q[r_sel]];
    r_accept  = m_valid_q && m_ready_i;
    r_advance = r_accept && !m_last_q;
    r_done    = r_accept && m_last_q;
    for (int c = 0; c < 2; c++) begin
      pop[c]       = (r_start && (r_pick == 1'(c))) || (r_advance && (r_ch_q == 1'(c)));
      frame_dec[c] = r_done && (r_ch_q == 1'(c));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c]  <= '0;
        rd_ptr_q[c]  <= '0;
        occ_q[c]     <= '0;
        frames_q[c]  <= '0;
        drop_q[c]    <= '0;
        w_state_q[c] <= WIdle;
        w_rem_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        w_state_q[c] <= w_state_d[c];
        w_rem_q[c]   <= w_rem_d[c];
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        occ_q[c]    <= occ_q[c] + {{AW{1'b0}}, push[c]} - {{AW{1'b0}}, pop[c]};
        frames_q[c] <= frames_q[c] + {{AW{1'b0}}, frame_done[c]} - {{AW{1'b0}}, frame_dec[c]};
        if (drop[c] && drop_q[c] != 16'hFFFF) drop_q[c] <= drop_q[c] + 16'd1;
      end
    end
  end

  // Reader: the header is popped into the output register as the frame is selected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q     <= RIdle;
      r_ch_q        <= 1'b0;
      last_served_q <= 1'b0;
      r_rem_q       <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
    end else if (r_start) begin
      r_state_q <= RStream;
      r_ch_q    <= r_pick;
      m_valid_q <= 1'b1;
      m_last_q  <= 1'b0;
      m_data_q  <= rd_word;
      r_rem_q   <= {1'b0, rd_word[LEN_WIDTH-1:0]} + 1'b1;
    end else if (r_advance) begin
      m_data_q <= rd_word;
      r_rem_q  <= r_rem_q - 1'b1;
      m_last_q <= (r_rem_q == RemOne);
    end else if (r_done) begin
      r_state_q     <= RIdle;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      last_served_q <= r_ch_q;
    end
  end

`ifdef FRAME_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 2'b00;
    else         err_q <= err_d;
  end
  assign check_err_o = err_q;
`else
  assign check_err_o = 2'b00;
`endif

  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign m_last_o    = m_last_q;
  assign m_ch_o      = r_ch_q;
  assign drop_cnt0_o = drop_q[0];
  assign drop_cnt1_o = drop_q[1];

endmodule

// File: tb/tb_two_ch_frame_merger.sv
// Bench for two_ch_frame_merger: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue-based frame model.
module tb_two_ch_frame_merger;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [63:0] ch0_data = '0, ch1_data = '0;
  logic        m_ready = 1'b0;
  logic        m_valid, m_last, m_ch;
  logic [63:0] m_data;
  logic [15:0] drop_cnt0, drop_cnt1;
  logic [1:0]  check_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two_ch_frame_merger dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ch0_valid_i(ch0_valid),
    .ch0_data_i (ch0_data),
    .ch1_valid_i(ch1_valid),
    .ch1_data_i (ch1_data),
    .m_ready_i  (m_ready),
    .m_valid_o  (m_valid),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .m_ch_o     (m_ch),
    .drop_cnt0_o(drop_cnt0),
    .drop_cnt1_o(drop_cnt1),
    .check_err_o(check_err)
  );

  // Model state: per-channel stored words, complete-frame counts, writer mode, output word.
  logic [63:0] fq [2][$];
  logic [63:0] sq [2][$];
  int          avail [2];
  int          wmode [2];
  int          wrem [2];
  int          drops [2];
  logic [1:0]  cerr;
  bit          mv, ml, mch, last_served;
  logic [63:0] md;
  int          rrem;
  int          acc_cnt;
  bit          first_seen;
  logic [63:0] first_acc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      fq[c].delete();
      sq[c].delete();
      avail[c] = 0; wmode[c] = 0; wrem[c] = 0; drops[c] = 0;
    end
    cerr = 2'b00; mv = 0; ml = 0; mch = 0; last_served = 0; md = '0; rrem = 0;
    acc_cnt = 0; first_seen = 0; first_acc = '0;
  endtask

  task automatic model_step(bit v0, logic [63:0] d0, bit v1, logic [63:0] d1, bit rdy);
    bit v [2];
    logic [63:0] d [2];
    int occ [2];
    int len;
    v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1;
    occ[0] = fq[0].size(); occ[1] = fq[1].size();
    if (mv) begin
      if (rdy) begin
        if (ml) begin
          avail[mch]--; last_served = mch; mv = 0; ml = 0;
        end else begin
          md = fq[mch].pop_front(); rrem--; ml = (rrem == 0);
        end
      end
    end else if (avail[0] > 0 || avail[1] > 0) begin
      mch = (avail[0] > 0 && avail[1] > 0) ? !last_served : (avail[1] > 0);
      md = fq[mch].pop_front(); mv = 1; ml = 0; rrem = int'(md[9:0]) + 1;
    end
    for (int c = 0; c < 2; c++) begin
      if (v[c]) begin
        case (wmode[c])
          0: begin
            len = int'(d[c][9:0]);
`ifdef FRAME_CHECK_EN
            if (d[c][63:48] != 16'hAAAA) cerr[c] = 1'b1;
            else
`endif
            if (len == 0 || DEPTH - occ[c] < len + 2) begin
              if (drops[c] < 65535) drops[c]++;
              wmode[c] = 2; wrem[c] = len + 1;
            end else begin
              fq[c].push_back(d[c]); wmode[c] = 1; wrem[c] = len + 1;
            end
          end
          1: begin
            fq[c].push_back(d[c]); wrem[c]--;
            if (wrem[c] == 0) begin
              wmode[c] = 0; avail[c]++;
`ifdef FRAME_CHECK_EN
              if (d[c][15:0] != 16'h5555) cerr[c] = 1'b1;
`endif
            end
          end
          default: begin
            wrem[c]--;
            if (wrem[c] == 0) wmode[c] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic compare();
    chk("m_valid", m_valid, mv);
    chk("m_last", m_last, ml);
    if (mv) begin
      chk("m_data", m_data, md);
      chk("m_ch", m_ch, mch);
    end
    chk("drop_cnt0", drop_cnt0, drops[0]);
    chk("drop_cnt1", drop_cnt1, drops[1]);
    chk("check_err", check_err, cerr);
  endtask

  task automatic step();
    bit rdy;
    rdy = m_ready;
    if (m_valid && m_ready) begin
      acc_cnt++;
      if (!first_seen) begin first_seen = 1; first_acc = m_data; end
    end
    @(posedge clk);
    model_step(ch0_valid, ch0_data, ch1_valid, ch1_data, rdy);
    #1;
    compare();
  endtask

  function automatic int rand_len();
    int r;
    r = $urandom_range(99);
    if (r < 3) return 0;
    if (r < 10) return $urandom_range(300, 100);
    return $urandom_range(16, 1);
  endfunction

  task automatic make_frame(int c, int len);
    logic [9:0] l;
    l = len[9:0];
    sq[c].push_back({16'hAAAA, $urandom(), 6'h0, l});
    for (int i = 0; i < len; i++) sq[c].push_back({$urandom(), $urandom()});
    sq[c].push_back({$urandom(), 16'($urandom()), 16'h5555});
  endtask

  task automatic tick(int pv, bit refill);
    bit v [2];
    logic [63:0] d [2];
    for (int c = 0; c < 2; c++) begin
      if (refill && sq[c].size() == 0) make_frame(c, rand_len());
      v[c] = 0; d[c] = '0;
      if (sq[c].size() != 0 && $urandom_range(99) < pv) begin
        v[c] = 1; d[c] = sq[c].pop_front();
      end
    end
    ch0_valid = v[0]; ch0_data = d[0];
    ch1_valid = v[1]; ch1_data = d[1];
    step();
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_ch", m_ch, 1'b0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_drop_cnt0", drop_cnt0, 16'h0);
    chk("rst_drop_cnt1", drop_cnt1, 16'h0);
    chk("rst_check_err", check_err, 2'b00);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] pat;
    logic        ch_a, ch_b;
    model_reset();

    // Single frame on CH0
    do_reset();
    m_ready = 1'b1;
    sq[0].push_back(64'hAAAA_0000_0000_0004);
    for (int i = 1; i <= 4; i++) sq[0].push_back(64'h1111_0000_0000_0000 + 64'(i));
    sq[0].push_back(64'h0000_0000_0000_5555);
    repeat (6) tick(100, 0);
    chk("single_no_valid_n1", m_valid, 1'b0);
    tick(0, 0);
    chk("single_valid_n2", m_valid, 1'b1);
    chk("single_header", m_data, 64'hAAAA_0000_0000_0004);
    chk("single_ch", m_ch, 1'b0);
    repeat (5) tick(0, 0);
    chk("single_last", m_last, 1'b1);
    chk("single_footer", m_data, 64'h0000_0000_0000_5555);
    tick(0, 0);
    chk("single_words", acc_cnt, 6);
    chk("single_gap_after", m_valid, 1'b0);

    // Round-robin: two simultaneous pairs, CH1 then CH0 each time
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        sq[c].push_back(64'hAAAA_0000_0000_0002 | (64'(c) << 32));
        sq[c].push_back(64'(k * 16 + c * 4 + 1));
        sq[c].push_back(64'(k * 16 + c * 4 + 2));
        sq[c].push_back(64'h0000_0000_0000_5555);
      end
      repeat (4) tick(100, 0);
      pat = '0; ch_a = 1'b0; ch_b = 1'b1;
      for (int i = 0; i < 12; i++) begin
        pat[i] = m_valid;
        if (i == 1) ch_a = m_ch;
        if (i == 6) ch_b = m_ch;
        tick(0, 0);
      end
      chk("rr_valid_pattern", 64'(pat), 64'h3DE);
      chk("rr_first_ch1", ch_a, 1'b1);
      chk("rr_second_ch0", ch_b, 1'b0);
    end

    // Backpressure during an L=8 frame
    do_reset();
    make_frame(0, 8);
    for (int i = 0; i < 80; i++) begin
      m_ready = 1'($urandom_range(1));
      tick(100, 0);
    end
    m_ready = 1'b1;
    repeat (5) tick(0, 0);
    chk("bp_words", acc_cnt, 10);

    // Overflow on CH0
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) make_frame(0, 98);
    make_frame(0, 7);
    while (sq[0].size() != 0) tick(100, 0);
    make_frame(0, 4);
    repeat (6) tick(100, 0);
    chk("ovf_drop0", drop_cnt0, 16'd1);
    m_ready = 1'b1;
    repeat (600) tick(0, 0);
    chk("ovf_drained", acc_cnt, 509);
    make_frame(0, 4);
    repeat (16) tick(100, 0);
    chk("ovf_next_frame", acc_cnt, 515);
    chk("ovf_drop0_after", drop_cnt0, 16'd1);

    // Length zero on CH1
    do_reset();
    m_ready = 1'b1;
    sq[1].push_back(64'hAAAA_0000_0000_0000);
    sq[1].push_back(64'hDEAD_BEEF_0000_0001);
    sq[1].push_back(64'hAAAA_0000_0001_0001);
    sq[1].push_back(64'h0000_0000_0000_00D1);
    sq[1].push_back(64'h0000_0000_0000_5555);
    repeat (14) tick(100, 0);
    chk("len0_drop1", drop_cnt1, 16'd1);
    chk("len0_words", acc_cnt, 3);
    chk("len0_first", first_acc, 64'hAAAA_0000_0001_0001);

`ifdef FRAME_CHECK_EN
    do_reset();
    m_ready = 1'b1;
    sq[0].push_back(64'h1234_5678_9ABC_DEF0);
    sq[0].push_back(64'hAAAA_0000_0000_0001);
    sq[0].push_back(64'h0000_0000_0000_00C1);
    sq[0].push_back(64'h0000_0000_0000_5A5A);
    repeat (12) tick(100, 0);
    chk("chk_err", check_err, 2'b01);
    chk("chk_words", acc_cnt, 3);
    chk("chk_first", first_acc, 64'hAAAA_0000_0000_0001);
`endif

    // Random traffic with varying downstream readiness, then a mid-frame reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i < 1000)      m_ready = 1'b1;
      else if (i < 2000) m_ready = 1'($urandom_range(1));
      else if (i < 2400) m_ready = 1'b0;
      else               m_ready = ($urandom_range(99) < 80);
      tick(70, 1);
    end
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      m_ready = ($urandom_range(99) < 60);
      tick(60, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/two_ch_frame_merger.md
# two_ch_frame_merger

Merges the framed 64-bit word streams of two per-channel data-frame generators into one stream for the readout path. Each channel stream has no backpressure, so the block buffers each channel in its own internal word FIFO, admits only frames that fit, and forwards complete frames one at a time with round-robin arbitration. The output is a valid/ready stream with a last-word marker and a channel tag.

## Interface
- DATA_WIDTH, 64: word width; the header and footer are one word each.
- LEN_WIDTH, 10: width of the frame-length field in header bits [LEN_WIDTH-1:0]. The field gives the number of data words between header and footer.
- FIFO_DEPTH, 512: words per channel FIFO; must be a power of 2 and ≥ 4.
- CLK  in  1  single clock for the whole block.
- RESET_N  in  1  asynchronous, active-low reset.
- CH0_VALID  in  1  channel-0 word strobe; no ready exists.
- CH0_DATA  in  DATA_WIDTH  channel-0 word.
- CH1_VALID  in  1  channel-1 word strobe.
- CH1_DATA  in  DATA_WIDTH  channel-1 word.
- M_READY  in  1  downstream accept.
- M_VALID  out  1  output word valid.
- M_DATA  out  DATA_WIDTH  output word.
- M_LAST  out  1  high on the footer word.
- M_CH  out  1  source channel of the current frame.
- DROP_CNT0, DROP_CNT1  out  16 each  frames dropped per channel; saturates at 16'hFFFF.
- CHECK_ERR  out  2  sticky framing-error flag per channel.

## Operation
- Every output resets to zero.
- Per-channel writer states are W_IDLE, W_ACCEPT and W_DISCARD.
- W_IDLE: a valid word is treated as a header with L = DATA[LEN_WIDTH-1:0]. The frame size is L+2 words.
  - If L==0, or free space < L+2 → W_DISCARD, and the drop counter increments.
  - Otherwise write the header → W_ACCEPT.
- W_ACCEPT: write each valid word and count it. After the footer (word L+2) is written → W_IDLE, and the channel's complete-frame counter increments.
- W_DISCARD: drop words until L+1 further valid words have passed → W_IDLE. Nothing is written.
- Free space is FIFO_DEPTH minus occupancy and is evaluated in the header cycle. Reads in that cycle are not credited.
- Reader states are R_IDLE and R_STREAM.
- R_IDLE arbitration:
  - When at least one channel's complete-frame counter is > 0, pick a channel and go to R_STREAM.
  - If both channels qualify, pick the channel not served last. After reset, channel 0 counts as last served, so channel 1 is picked first.
  - M_CH latches the chosen channel.
- R_STREAM: output the FIFO words in order.
  - M_LAST=1 on word L+2. L is taken from the header as it leaves the FIFO.
  - When the last word is accepted, decrement that channel's frame counter → R_IDLE.
- Simultaneous events are all legal and must not lose a count or a word:
  - a frame counter incrementing and decrementing in the same cycle;
  - FIFO write and read in the same cycle;
  - both channels completing frames in the same cycle.
- When RESET_N is asserted mid-frame, all FIFOs, counters and state clear immediately. Partial frames are lost. The input is resynchronised at the next word, which is treated as a header.

## Timing
- Frame availability: a footer written on cycle N gives a frame counter > 0 on N+1.
- Start of output: if the reader is idle, M_VALID first rises on N+2 with the header on M_DATA.
- Handshake:
  - M_DATA, M_LAST and M_CH are held stable while M_VALID=1 and M_READY=0.
  - With M_READY held at 1, one word is transferred per cycle.
- After the last word of a frame is accepted, M_VALID is 0 for exactly one cycle (the R_IDLE cycle) before the next frame.
- M_VALID never depends combinationally on M_READY.
- Write path: a word presented with CHx_VALID on cycle N is stored on cycle N, with no input register beyond the FIFO write.

## Configuration
- FRAME_CHECK_EN defined:
  - In W_IDLE, a word whose bits [63:48] ≠ 16'hAAAA is discarded and sets CHECK_ERR[ch]; the writer stays in W_IDLE.
  - A footer whose bits [15:0] ≠ 16'h5555 sets CHECK_ERR[ch], but the frame is still forwarded.
- FRAME_CHECK_EN undefined:
  - No ID checks are made; every W_IDLE word is treated as a header.
  - CHECK_ERR is tied to 0.

## Test plan
- Single frame: CH0 sends header 0xAAAA…0004, 4 data words, footer …5555 (M_READY=1). Expect M_VALID rising 2 cycles after the footer, 6 contiguous words, M_LAST on word 6, M_CH=0.
- Round-robin: both channels complete L=2 frames in the same cycle. Expect the CH1 frame first, a 1-cycle gap, then the CH0 frame. A second simultaneous pair is also output CH1 then CH0.
- Backpressure: toggle M_READY randomly during an L=8 frame. Expect no lost or duplicated words and data held stable while stalled.
- Overflow:
  - Fill the CH0 FIFO with FIFO_DEPTH-3 words of frames, keeping M_READY=0.
  - Send an L=4 frame: it is dropped, DROP_CNT0=1, and no words are stored.
  - Release M_READY: the next frame is accepted normally.
- Length zero: header with L=0 followed by one word. Expect both words discarded, DROP_CNT1=1, and the next header accepted.
- Check (FRAME_CHECK_EN): stray word 0x1234… in W_IDLE, then a frame with footer ID 0x5A5A. Expect CHECK_ERR[0]=1, the stray word not forwarded, and the frame forwarded intact.
